// File: rtl/serial_cmp_pkg.sv
// -----------------------------------------------------------------------------
// serial_cmp_pkg
// Shared types for the bit-serial magnitude comparator:
//   cmp_state_e   - controller state (IDLE / SCAN / DONE)
//   cmp_result_t  - one-hot {eq, lt, gt} result
//   RES_*         - result encodings, plus helpers for one-hot checks
// Optional feature macro used elsewhere in this slice: SERIAL_CMP_SIGNED_EN.
// -----------------------------------------------------------------------------
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } cmp_state_e;

  typedef struct packed {
    logic eq;
    logic lt;
    logic gt;
  } cmp_result_t;

  localparam cmp_result_t RES_NONE = 3'b000;
  localparam cmp_result_t RES_EQ   = 3'b100;
  localparam cmp_result_t RES_LT   = 3'b010;
  localparam cmp_result_t RES_GT   = 3'b001;

  // True when exactly one of eq/lt/gt is set.
  function automatic logic result_is_onehot(input cmp_result_t r);
    return (r == RES_EQ) || (r == RES_LT) || (r == RES_GT);
  endfunction

  // Ordering result once a differing bit has been found.
  function automatic cmp_result_t order_result(input logic a_greater);
    return a_greater ? RES_GT : RES_LT;
  endfunction

endpackage

// File: rtl/serial_comparator_if.sv
// -----------------------------------------------------------------------------
// serial_comparator_if
// Operand and result handshakes of the serial comparator.
// Handshake rule (both channels): a transfer happens on a rising clk edge
// where valid && ready; valid and its payload stay stable until then.
//   master : drives in_valid, A, B, out_ready
//   slave  : drives in_ready, out_valid, eq, lt, gt, bits_used
// -----------------------------------------------------------------------------
interface serial_comparator_if #(
  parameter int N = 4
);
  localparam int CW = $clog2(N + 1);

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  A;
  logic [N-1:0]  B;
  logic          out_valid;
  logic          out_ready;
  logic          eq;
  logic          lt;
  logic          gt;
  logic [CW-1:0] bits_used;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, eq, lt, gt, bits_used
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, eq, lt, gt, bits_used
  );

endinterface

// File: rtl/serial_cmp_bit_cell.sv
// -----------------------------------------------------------------------------
// serial_cmp_bit_cell
// Per-cycle decision for one bit position of the serial comparator.
//   a_bit_i, b_bit_i : current MSB of each shift register
//   is_msb_i         : this is the first (sign) bit of the scan
//   differ_o         : bits differ, a decision is made this cycle
//   a_greater_o      : when differ_o, A is the larger operand
// Macro SERIAL_CMP_SIGNED_EN: treat operands as two's complement.
// -----------------------------------------------------------------------------
module serial_cmp_bit_cell (
  input  logic a_bit_i,
  input  logic b_bit_i,
  input  logic is_msb_i,
  output logic differ_o,
  output logic a_greater_o
);

  assign differ_o = a_bit_i ^ b_bit_i;

`ifdef SERIAL_CMP_SIGNED_EN
  // The sign bit carries negative weight, so a 1 in A's MSB makes A smaller.
  assign a_greater_o = is_msb_i ? b_bit_i : a_bit_i;
`else
  logic unused_is_msb;
  assign unused_is_msb = is_msb_i;
  assign a_greater_o   = a_bit_i;
`endif

endmodule

// File: rtl/serial_comparator.sv
// -----------------------------------------------------------------------------
// serial_comparator
// Bit-serial magnitude comparator. Accepts A/B, scans MSB-first one bit per
// cycle, stops at the first differing bit and reports one-hot eq/lt/gt plus
// the number of bits examined.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : serial_comparator_if.slave (operand + result handshakes)
//   state_o    : current controller state (debug)
// Macro SERIAL_CMP_SIGNED_EN (via serial_cmp_bit_cell): signed comparison.
// -----------------------------------------------------------------------------
module serial_comparator
  import serial_cmp_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_comparator_if.slave  bus,
  output cmp_state_e          state_o
);

  localparam int CW   = $clog2(N + 1);
  localparam int CNTW = (N > 1) ? $clog2(N) : 1;

  cmp_state_e    state_q;
  logic [N-1:0]  a_sh_q;
  logic [N-1:0]  b_sh_q;
  logic [CNTW-1:0] cnt_q;
  logic [CW-1:0] bits_used_q;
  cmp_result_t   res_q;
  logic          in_ready_q;
  logic          out_valid_q;

  logic          msb_cycle;
  logic          differ;
  logic          a_greater;

  // The counter is loaded with N-1 on accept, so it still holds N-1 during
  // the first SCAN cycle, which is the one looking at the sign bit.
  assign msb_cycle = (cnt_q == CNTW'(N - 1));

  serial_cmp_bit_cell u_bit_cell (
    .a_bit_i     (a_sh_q[N-1]),
    .b_bit_i     (b_sh_q[N-1]),
    .is_msb_i    (msb_cycle),
    .differ_o    (differ),
    .a_greater_o (a_greater)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      cnt_q       <= '0;
      bits_used_q <= '0;
      res_q       <= RES_NONE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            a_sh_q      <= bus.A;
            b_sh_q      <= bus.B;
            cnt_q       <= CNTW'(N - 1);
            bits_used_q <= '0;
            in_ready_q  <= 1'b0;
            state_q     <= SCAN;
          end
        end
        SCAN: begin
          bits_used_q <= bits_used_q + CW'(1);
          if (differ) begin
            res_q       <= order_result(a_greater);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if (cnt_q == '0) begin
            res_q       <= RES_EQ;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            a_sh_q <= a_sh_q << 1;
            b_sh_q <= b_sh_q << 1;
            cnt_q  <= cnt_q - CNTW'(1);
          end
        end
        DONE: begin
          // Result registers are untouched here, so they hold under
          // back-pressure and keep their value after the handshake.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.eq        = res_q.eq;
  assign bus.lt        = res_q.lt;
  assign bus.gt        = res_q.gt;
  assign bus.bits_used = bits_used_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_serial_comparator.sv
// -----------------------------------------------------------------------------
// tb_serial_comparator
// Directed bench for serial_comparator: an N=4 instance for the main checks
// and an N=1 instance for the single-bit corner. Expected results are
// hand-computed; SERIAL_CMP_SIGNED_EN selects the signed expectations.
// -----------------------------------------------------------------------------
module tb_serial_comparator;
  import serial_cmp_pkg::*;

  typedef struct {
    logic [3:0]  a;
    logic [3:0]  b;
    cmp_result_t r;
    logic [2:0]  bits;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_comparator_if #(.N(4)) bus ();
  cmp_state_e state;
  serial_comparator #(.N(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (state)
  );

  serial_comparator_if #(.N(1)) bus1 ();
  cmp_state_e state1;
  serial_comparator #(.N(1)) dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus1),
    .state_o (state1)
  );

  // ---------------- scoreboard ----------------
  int         tests_run    = 0;
  int         tests_failed = 0;
  logic [5:0] exp_q[$];
  logic [5:0] exp_v;
  logic [5:0] got_v;

  // ---------------- driver tasks ----------------
  // Present a pair for one accept edge, then scramble A/B so a late
  // sample of the operands would show up in the result.
  task automatic drive_pair(input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.A        = a;
    bus.B        = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.A        = 4'($urandom_range(0, 15));
    bus.B        = 4'($urandom_range(0, 15));
  endtask

  // Count rising edges until out_valid, bounded at 20.
  task automatic wait_out(output int edges);
    edges = 0;
    while (bus.out_valid !== 1'b1 && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    got_v = {bus.eq, bus.lt, bus.gt, bus.bits_used};
    tests_run++;
    if (got_v !== 6'b000_000 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || state !== IDLE) begin
      tests_failed++;
      $display("FAIL reset_values: res/bits=%b in_ready=%b out_valid=%b state=%0d, need 000000 1 0 IDLE",
               got_v, bus.in_ready, bus.out_valid, state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || state !== IDLE) begin
      tests_failed++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b state=%0d, need 1 0 IDLE",
               bus.in_ready, bus.out_valid, state);
    end
  endtask

  task automatic test_compare_table;
    vec_t vecs[5];
    int   edges;
`ifdef SERIAL_CMP_SIGNED_EN
    vecs[0] = '{a: 4'b1010, b: 4'b0110, r: RES_LT, bits: 3'd1};
    vecs[4] = '{a: 4'b1000, b: 4'b0001, r: RES_LT, bits: 3'd1};
`else
    vecs[0] = '{a: 4'b1010, b: 4'b0110, r: RES_GT, bits: 3'd1};
    vecs[4] = '{a: 4'b1000, b: 4'b0001, r: RES_GT, bits: 3'd1};
`endif
    vecs[1] = '{a: 4'd5,    b: 4'd5,    r: RES_EQ, bits: 3'd4};
    vecs[2] = '{a: 4'b0100, b: 4'b0101, r: RES_LT, bits: 3'd4};
    vecs[3] = '{a: 4'b0101, b: 4'b0100, r: RES_GT, bits: 3'd4};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_pair(vecs[i].a, vecs[i].b);
      exp_q.push_back({vecs[i].r, vecs[i].bits});
      wait_out(edges);
      tests_run++;
      if (edges != int'(vecs[i].bits)) begin
        tests_failed++;
        $display("FAIL latency_vec%0d: out_valid after %0d edges, need %0d", i, edges, vecs[i].bits);
      end
      exp_v = exp_q.pop_front();
      got_v = {bus.eq, bus.lt, bus.gt, bus.bits_used};
      tests_run++;
      if (got_v !== exp_v) begin
        tests_failed++;
        $display("FAIL result_vec%0d: eq/lt/gt/bits=%b, need %b", i, got_v, exp_v);
      end
      tests_run++;
      if (!result_is_onehot({bus.eq, bus.lt, bus.gt})) begin
        tests_failed++;
        $display("FAIL onehot_vec%0d: eq/lt/gt=%b%b%b, need one-hot", i, bus.eq, bus.lt, bus.gt);
      end
      @(posedge clk);
      #1;
      tests_run++;
      if (state !== IDLE || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL idle_vec%0d: state=%0d out_valid=%b in_ready=%b, need IDLE 0 1",
                 i, state, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_backpressure;
    int edges;
    bus.out_ready = 1'b0;
    drive_pair(4'b0110, 4'b0011);
    exp_q.push_back({RES_GT, 3'd2});
    wait_out(edges);
    tests_run++;
    if (edges != 2) begin
      tests_failed++;
      $display("FAIL bp_latency: out_valid after %0d edges, need 2", edges);
    end
    exp_v = exp_q.pop_front();
    // New pair offered while the result is stalled must not be taken.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.A        = 4'b0000;
    bus.B        = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      got_v = {bus.eq, bus.lt, bus.gt, bus.bits_used};
      tests_run++;
      if (got_v !== exp_v || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || state !== DONE) begin
        tests_failed++;
        $display("FAIL bp_hold_c%0d: res/bits=%b out_valid=%b in_ready=%b state=%0d, need %b 1 0 DONE",
                 c, got_v, bus.out_valid, bus.in_ready, state, exp_v);
      end
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (state !== IDLE || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_release: state=%0d out_valid=%b in_ready=%b, need IDLE 0 1",
               state, bus.out_valid, bus.in_ready);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (state !== SCAN || bus.in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_next_accept: state=%0d in_ready=%b, need SCAN 0", state, bus.in_ready);
    end
    bus.in_valid = 1'b0;
    exp_q.push_back({RES_LT, 3'd4});
    wait_out(edges);
    tests_run++;
    if (edges != 4) begin
      tests_failed++;
      $display("FAIL bp_next_latency: out_valid after %0d edges, need 4", edges);
    end
    exp_v = exp_q.pop_front();
    got_v = {bus.eq, bus.lt, bus.gt, bus.bits_used};
    tests_run++;
    if (got_v !== exp_v) begin
      tests_failed++;
      $display("FAIL bp_next_result: eq/lt/gt/bits=%b, need %b", got_v, exp_v);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_scan;
    bus.out_ready = 1'b1;
    drive_pair(4'd5, 4'd5);
    @(posedge clk);
    #1;
    tests_run++;
    if (state !== SCAN || bus.bits_used !== 3'd1) begin
      tests_failed++;
      $display("FAIL midscan_pre: state=%0d bits_used=%0d, need SCAN 1", state, bus.bits_used);
    end
    #1;
    rst_n = 1'b0;
    #1;
    got_v = {bus.eq, bus.lt, bus.gt, bus.bits_used};
    tests_run++;
    if (got_v !== 6'b000_000 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || state !== IDLE) begin
      tests_failed++;
      $display("FAIL midscan_async: res/bits=%b in_ready=%b out_valid=%b state=%0d, need 000000 1 0 IDLE",
               got_v, bus.in_ready, bus.out_valid, state);
    end
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || state !== IDLE) begin
        tests_failed++;
        $display("FAIL midscan_after_c%0d: out_valid=%b in_ready=%b state=%0d, need 0 1 IDLE",
                 c, bus.out_valid, bus.in_ready, state);
      end
    end
  endtask

  task automatic test_n1;
    logic [1:0] pairs[2];
    logic [5:0] exps[2];
    int         edges;
    pairs[0] = 2'b10;
    pairs[1] = 2'b11;
`ifdef SERIAL_CMP_SIGNED_EN
    exps[0] = {RES_LT, 3'd1};
`else
    exps[0] = {RES_GT, 3'd1};
`endif
    exps[1] = {RES_EQ, 3'd1};
    bus1.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus1.in_valid = 1'b1;
      bus1.A        = pairs[i][1];
      bus1.B        = pairs[i][0];
      @(posedge clk);
      #1;
      bus1.in_valid = 1'b0;
      bus1.A        = 1'($urandom_range(0, 1));
      bus1.B        = 1'($urandom_range(0, 1));
      exp_q.push_back(exps[i]);
      edges = 0;
      while (bus1.out_valid !== 1'b1 && edges < 20) begin
        @(posedge clk);
        #1;
        edges++;
      end
      tests_run++;
      if (edges != 1) begin
        tests_failed++;
        $display("FAIL n1_latency_%0d: out_valid after %0d edges, need 1", i, edges);
      end
      exp_v = exp_q.pop_front();
      got_v = {bus1.eq, bus1.lt, bus1.gt, 2'b00, bus1.bits_used};
      tests_run++;
      if (got_v !== exp_v) begin
        tests_failed++;
        $display("FAIL n1_result_%0d: eq/lt/gt/bits=%b, need %b", i, got_v, exp_v);
      end
      @(posedge clk);
      #1;
      tests_run++;
      if (state1 !== IDLE || bus1.in_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL n1_idle_%0d: state=%0d in_ready=%b, need IDLE 1", i, state1, bus1.in_ready);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    bus.in_valid   = 1'b0;
    bus.A          = '0;
    bus.B          = '0;
    bus.out_ready  = 1'b1;
    bus1.in_valid  = 1'b0;
    bus1.A         = '0;
    bus1.B         = '0;
    bus1.out_ready = 1'b1;

    test_reset();
    test_compare_table();
    test_backpressure();
    test_reset_mid_scan();
    test_n1();

    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d entries left, need 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/serial_comparator.md
Name: serial_comparator

Overview:
- Multi-cycle, bit-serial magnitude comparator for the ALU.
- Accepts an operand pair A/B through a valid/ready handshake.
- Scans the operands MSB-first, one bit per cycle, and stops early at the first differing bit.
- Returns a one-hot eq/lt/gt result plus the number of bits examined through a second valid/ready handshake. Sits beside the combinational equality unit and adds ordering results for area-constrained datapaths.

Parameters:
- N, 4, operand width in bits (N >= 1)
- CW, $clog2(N+1), width of bits_used (derived, not overridden)

Ports:
- clk  input  1  system clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept an operand pair
- A  input  N  operand A
- B  input  N  operand B
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- eq  output  1  A == B
- lt  output  1  A < B
- gt  output  1  A > B
- bits_used  output  CW  bits compared before decision (1..N)

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, in_ready=1, out_valid=0, eq=lt=gt=0, bits_used=0, shift registers and counter cleared.
- States:
  - IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready, latch A/B into shift registers, counter=N-1, bits_used=0, go to SCAN.
  - SCAN: in_ready=0. Each cycle compare a_sh[N-1] with b_sh[N-1] and increment bits_used.
    - Bits differ: set gt=a_sh[N-1], lt=b_sh[N-1], eq=0, go to DONE.
    - Bits equal and counter==0: set eq=1, lt=gt=0, go to DONE.
    - Otherwise: shift both registers left by 1, decrement counter, stay in SCAN.
  - DONE: out_valid=1. eq/lt/gt/bits_used held stable while out_valid&&!out_ready. On out_valid&&out_ready, go to IDLE. Result outputs keep their last values until the next decision.
- Latency: out_valid asserts d rising edges after the accept edge, where d = bits_used (1..N).
- Throughput: no back-to-back acceptance; at least one IDLE cycle between operations. Minimum period d+2 cycles.
- Exactly one of eq/lt/gt is high whenever out_valid=1.
- in_valid while not in IDLE: ignored, not queued. Operands are sampled only at the accept edge; A/B changes afterwards have no effect.
- N=1: single SCAN cycle, bits_used=1 always.
- Reset asserted mid-SCAN or mid-DONE: immediate return to reset values; the in-flight operation is discarded, no out_valid pulse.

Optional Feature:
- Macro: SERIAL_CMP_SIGNED_EN.
- Defined: operands are two's complement. If the decision occurs at the first SCAN cycle (MSB, sign bit), lt/gt are swapped (a_sh[N-1]=1 gives lt=1). Later bits follow the unsigned rule. Latency is unchanged.
- Undefined: unsigned comparison only; no signed logic is synthesised.

Decomposition:
- Package serial_cmp_pkg holds:
  - state enum cmp_state_e {IDLE, SCAN, DONE}
  - struct cmp_result_t {eq, lt, gt}
  - localparam encoding helpers for one-hot result checks
- Sub-module: serial_cmp_bit_cell, the per-cycle decision (two input bits, is_msb flag, signed mode) producing differ/a_greater. It keeps the signed/unsigned rule in one place; the FSM, shift registers and counter stay in serial_comparator.

Test Plan (N=4 unless noted):
- A=4'b1010, B=4'b0110, out_ready=1 -> gt=1, eq=lt=0, bits_used=1, out_valid 1 edge after accept, then IDLE.
- A=4'd5, B=4'd5 -> eq=1, bits_used=4, out_valid 4 edges after accept.
- A=4'b0100, B=4'b0101 -> lt=1, bits_used=4. Swap operands -> gt=1, bits_used=4.
- A=4'b1000, B=4'b0001 -> with SERIAL_CMP_SIGNED_EN lt=1, bits_used=1; without it gt=1, bits_used=1.
- Result reached with out_ready=0 for 5 cycles while in_valid=1 with new operands -> outputs stable, in_ready=0, new pair not accepted; out_ready=1 -> IDLE, next pair accepted the following cycle.
- Operation accepted, rst_n pulsed low during the 2nd SCAN cycle -> all outputs at reset values asynchronously, no out_valid afterwards, in_ready=1 after release; N=1 build with A=1, B=0 -> gt=1, bits_used=1.
